step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter BASE_PERIOD, default 12_500_000: step interval in clk cycles at snake_length 0, normal speed.
REQ-002 Parameter MIN_PERIOD, default 2_500_000: floor on step interval before slow scaling.
REQ-003 Parameter SPEEDUP_STEP, default 250_000: interval reduction per 4 body segments.
REQ-004 clk  input  1  system clock, 50 MHz; single clock domain.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 game_state  input  2  00 RUNNING, 01 DIE, 10 INITIAL.
REQ-007 pause  input  1  level; high freezes the step timer.
REQ-008 slow  input  1  level; high doubles the step interval.
REQ-009 snake_length  input  6  current body length, 0..63.
REQ-010 move_ack  input  1  snake datapath completed one move.
REQ-011 hit  input  1  hit_boundary OR hit_self from snake datapath.
REQ-012 get_food  input  1  head on food.
REQ-013 move_req  output  1  level request for one snake move.
REQ-014 check_en  output  1  one-cycle collision/food evaluation strobe.
REQ-015 grow_en  output  1  one-cycle growth/new-food strobe.
REQ-016 die_pulse  output  1  one-cycle death event to fsm.
REQ-017 phase  output  3  current sequencer state encoding.
REQ-018 step_count  output  16  completed steps since entering RUNNING, wraps at 65535->0.

Function
REQ-019 States SHALL be IDLE, WAIT, MOVE, CHECK, EVAL, DEAD; phase reflects the state.
REQ-020 Any state SHALL go to IDLE whenever game_state != RUNNING, aborting mid-sequence; move_req drops the next cycle.
REQ-021 IDLE -> WAIT when game_state == RUNNING; step_count and timer cleared on this transition.
REQ-022 Interval P = max(BASE_PERIOD - (snake_length>>2)*SPEEDUP_STEP, MIN_PERIOD), doubled when slow; computed in 26 bits with no underflow.
REQ-023 P SHALL be latched on each entry to WAIT; slow/length changes take effect next interval.
REQ-024 In WAIT the timer increments each cycle unless pause is high (holds value); at count P-1 with pause low, timer clears and state -> MOVE.
REQ-025 Timer SHALL be held at 0 outside WAIT; effective step period = P + sequence latency.
REQ-026 MOVE asserts move_req (registered) until move_ack sampled high; then -> CHECK; no timeout.
REQ-027 CHECK asserts check_en exactly one cycle, -> EVAL.
REQ-028 EVAL samples hit and get_food: hit -> die_pulse one cycle, -> DEAD; else get_food -> grow_en one cycle, -> WAIT; else -> WAIT.
REQ-029 hit SHALL take priority over get_food in the same EVAL cycle; grow_en then stays low.
REQ-030 step_count increments by 1 on every EVAL exit to WAIT or DEAD.
REQ-031 DEAD holds all strobes low until game_state leaves RUNNING.
REQ-032 pause SHALL NOT stall MOVE/CHECK/EVAL; an in-flight step completes.

Reset
REQ-033 On rst low: state IDLE, timer 0, latched P = BASE_PERIOD, move_req/check_en/grow_en/die_pulse 0, phase IDLE, step_count 0; release synchronous-deasserted at system level.

Structure
REQ-034 Shared package game_pkg SHALL hold game_state codes, direction codes, phase encodings and period defaults.
REQ-035 Sub-module step_timer SHALL implement the interval computation, latch and pausable counter, emitting a one-cycle expire.

Verification (BASE_PERIOD=20, MIN_PERIOD=8, SPEEDUP_STEP=2)
REQ-036 RUNNING, len 0, ack 1 cycle after req: move_req rises 20 cycles after WAIT entry; check_en 2 cycles later; step_count 1.
REQ-037 len 40, slow high: P = max(20-20,8)*2 = 16 cycles; len 8: P = 16, slow low.
REQ-038 pause high 5 cycles at timer 10: move_req delayed by exactly 5 cycles.
REQ-039 EVAL with hit=1, get_food=1: die_pulse one cycle, grow_en 0, phase DEAD, no further move_req.
REQ-040 game_state -> INITIAL while in MOVE awaiting ack: move_req low next cycle, phase IDLE; rst low mid-WAIT: all outputs reset values immediately.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | game_pkg : shared game codes, sequencer phases, period defaults   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package game_pkg;

  localparam logic [1:0] c_gs_running = 2'b00;
  localparam logic [1:0] c_gs_die     = 2'b01;
  localparam logic [1:0] c_gs_initial = 2'b10;

  localparam logic [1:0] c_dir_up    = 2'b00;
  localparam logic [1:0] c_dir_down  = 2'b01;
  localparam logic [1:0] c_dir_left  = 2'b10;
  localparam logic [1:0] c_dir_right = 2'b11;

  localparam int unsigned c_period_w     = 26;
  localparam int unsigned c_base_period  = 12_500_000;
  localparam int unsigned c_min_period   = 2_500_000;
  localparam int unsigned c_speedup_step = 250_000;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_WAIT  = 3'd1,
    PH_MOVE  = 3'd2,
    PH_CHECK = 3'd3,
    PH_EVAL  = 3'd4,
    PH_DEAD  = 3'd5
  } phase_e;

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | step_timer : length/slow scaled interval latch and pausable timer |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module step_timer
  import game_pkg::*;
#(
  parameter int unsigned BASE_PERIOD  = c_base_period,
  parameter int unsigned MIN_PERIOD   = c_min_period,
  parameter int unsigned SPEEDUP_STEP = c_speedup_step
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_run,
  input  logic       i_pause,
  input  logic       i_slow,
  input  logic [5:0] i_snake_length,
  output logic       o_expire
);

  localparam logic [25:0] c_base = 26'(BASE_PERIOD);
  localparam logic [25:0] c_min  = 26'(MIN_PERIOD);
  localparam logic [25:0] c_step = 26'(SPEEDUP_STEP);

  logic [25:0] period_q, period_d;
  logic [25:0] timer_q, timer_d;
  logic [5:0]  w_quarter;
  logic [25:0] w_reduce, w_diff, w_floor, w_period;

  assign o_expire = i_run && !i_pause && (timer_q == period_q - 26'd1);

  always_comb begin
    w_quarter = i_snake_length >> 2;
    w_reduce  = 26'(w_quarter) * c_step;
    // Clamp at zero first so a long body can never wrap the interval.
    w_diff    = (c_base > w_reduce) ? (c_base - w_reduce) : '0;
    w_floor   = (w_diff > c_min) ? w_diff : c_min;
    w_period  = i_slow ? {w_floor[24:0], 1'b0} : w_floor;

    period_d = i_load ? w_period : period_q;

    if (i_load || !i_run) begin
      timer_d = '0;
    end else if (i_pause) begin
      timer_d = timer_q;
    end else if (o_expire) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 26'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= c_base;
      timer_q  <= '0;
    end else begin
      period_q <= period_d;
      timer_q  <= timer_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | step_sequencer : paces snake moves WAIT->MOVE->CHECK->EVAL        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module step_sequencer
  import game_pkg::*;
#(
  parameter int unsigned BASE_PERIOD  = c_base_period,
  parameter int unsigned MIN_PERIOD   = c_min_period,
  parameter int unsigned SPEEDUP_STEP = c_speedup_step
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  game_state,
  input  logic        pause,
  input  logic        slow,
  input  logic [5:0]  snake_length,
  input  logic        move_ack,
  input  logic        hit,
  input  logic        get_food,
  output logic        move_req,
  output logic        check_en,
  output logic        grow_en,
  output logic        die_pulse,
  output logic [2:0]  phase,
  output logic [15:0] step_count
);

  phase_e      state_q, state_d;
  logic        move_req_q, move_req_d;
  logic        check_en_q, check_en_d;
  logic        grow_en_q, grow_en_d;
  logic        die_pulse_q, die_pulse_d;
  logic [15:0] step_count_q, step_count_d;
  logic        w_load;
  logic        w_expire;

  step_timer #(
    .BASE_PERIOD  (BASE_PERIOD),
    .MIN_PERIOD   (MIN_PERIOD),
    .SPEEDUP_STEP (SPEEDUP_STEP)
  ) u_step_timer (
    .clk            (clk),
    .rst            (rst),
    .i_load         (w_load),
    .i_run          (state_q == PH_WAIT),
    .i_pause        (pause),
    .i_slow         (slow),
    .i_snake_length (snake_length),
    .o_expire       (w_expire)
  );

  always_comb begin
    state_d      = state_q;
    step_count_d = step_count_q;
    grow_en_d    = 1'b0;
    die_pulse_d  = 1'b0;
    w_load       = 1'b0;

    if (game_state != c_gs_running) begin
      state_d = PH_IDLE;
    end else begin
      case (state_q)
        PH_IDLE: begin
          state_d      = PH_WAIT;
          step_count_d = '0;
          w_load       = 1'b1;
        end
        PH_WAIT:  if (w_expire) state_d = PH_MOVE;
        PH_MOVE:  if (move_ack) state_d = PH_CHECK;
        PH_CHECK: state_d = PH_EVAL;
        PH_EVAL: begin
          step_count_d = step_count_q + 16'd1;
          // Collision wins over food: a dying snake never grows.
          if (hit) begin
            state_d     = PH_DEAD;
            die_pulse_d = 1'b1;
          end else begin
            state_d   = PH_WAIT;
            grow_en_d = get_food;
            w_load    = 1'b1;
          end
        end
        PH_DEAD:  state_d = PH_DEAD;
        default:  state_d = PH_IDLE;
      endcase
    end

    move_req_d = (state_d == PH_MOVE);
    check_en_d = (state_d == PH_CHECK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PH_IDLE;
      move_req_q   <= 1'b0;
      check_en_q   <= 1'b0;
      grow_en_q    <= 1'b0;
      die_pulse_q  <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      move_req_q   <= move_req_d;
      check_en_q   <= check_en_d;
      grow_en_q    <= grow_en_d;
      die_pulse_q  <= die_pulse_d;
      step_count_q <= step_count_d;
    end
  end

  assign move_req   = move_req_q;
  assign check_en   = check_en_q;
  assign grow_en    = grow_en_q;
  assign die_pulse  = die_pulse_q;
  assign phase      = state_q;
  assign step_count = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_step_sequencer : directed checks of step pacing and events     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_step_sequencer;

  localparam logic [1:0] c_running = 2'b00;
  localparam logic [1:0] c_initial = 2'b10;
  localparam int c_ph_idle  = 0;
  localparam int c_ph_wait  = 1;
  localparam int c_ph_check = 3;
  localparam int c_ph_eval  = 4;
  localparam int c_ph_dead  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  game_state = c_initial;
  logic        pause = 1'b0;
  logic        slow = 1'b0;
  logic [5:0]  snake_length = 6'd0;
  logic        move_ack = 1'b0;
  logic        hit = 1'b0;
  logic        get_food = 1'b0;
  logic        move_req, check_en, grow_en, die_pulse;
  logic [2:0]  phase;
  logic [15:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int seen_req;

  step_sequencer #(
    .BASE_PERIOD  (20),
    .MIN_PERIOD   (8),
    .SPEEDUP_STEP (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_state   (game_state),
    .pause        (pause),
    .slow         (slow),
    .snake_length (snake_length),
    .move_ack     (move_ack),
    .hit          (hit),
    .get_food     (get_food),
    .move_req     (move_req),
    .check_en     (check_en),
    .grow_en      (grow_en),
    .die_pulse    (die_pulse),
    .phase        (phase),
    .step_count   (step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from now until move_req is seen high, bounded.
  task automatic wait_req(output int n);
    n = 0;
    while (!move_req && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Acknowledge one cycle after the request, then drive EVAL inputs and the
  // length/slow values that the following WAIT entry latches.
  task automatic do_step(input logic h, input logic f, input logic [5:0] len, input logic s);
    tick();
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    tick();
    hit = h; get_food = f; snake_length = len; slow = s;
    tick();
    hit = 1'b0; get_food = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    check("rst_phase", 32'(phase), c_ph_idle);
    check("rst_move_req", 32'(move_req), 0);
    check("rst_check_en", 32'(check_en), 0);
    check("rst_grow_die", 32'({grow_en, die_pulse}), 0);
    check("rst_step_count", 32'(step_count), 0);

    rst = 1'b1;
    tick();
    game_state = c_running;
    tick();
    check("enter_wait", 32'(phase), c_ph_wait);
    wait_req(cyc);
    check("p_len0", 32'(cyc), 20);
    tick();
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    check("check_en_on", 32'(check_en), 1);
    check("req_dropped", 32'(move_req), 0);
    check("phase_check", 32'(phase), c_ph_check);
    tick();
    check("check_en_one", 32'(check_en), 0);
    check("phase_eval", 32'(phase), c_ph_eval);
    get_food = 1'b1; snake_length = 6'd40; slow = 1'b1;
    tick();
    get_food = 1'b0;
    check("grow_en_on", 32'(grow_en), 1);
    check("count_1", 32'(step_count), 1);
    wait_req(cyc);
    check("p_len40_slow", 32'(cyc), 16);

    do_step(1'b0, 1'b0, 6'd8, 1'b0);
    check("grow_en_off", 32'(grow_en), 0);
    check("count_2", 32'(step_count), 2);
    wait_req(cyc);
    check("p_len8", 32'(cyc), 16);

    do_step(1'b0, 1'b0, 6'd8, 1'b0);
    repeat (10) tick();
    pause = 1'b1;
    repeat (5) tick();
    pause = 1'b0;
    wait_req(cyc);
    check("pause_delay", 32'(cyc), 6);

    pause = 1'b1;
    do_step(1'b1, 1'b1, 6'd8, 1'b0);
    pause = 1'b0;
    check("die_pulse_on", 32'(die_pulse), 1);
    check("hit_no_grow", 32'(grow_en), 0);
    check("phase_dead", 32'(phase), c_ph_dead);
    check("count_4", 32'(step_count), 4);
    tick();
    check("die_pulse_one", 32'(die_pulse), 0);
    seen_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (move_req) seen_req = 1;
      tick();
    end
    check("dead_no_req", 32'(seen_req), 0);

    game_state = c_initial;
    tick();
    check("leave_dead", 32'(phase), c_ph_idle);
    game_state = c_running;
    tick();
    check("count_cleared", 32'(step_count), 0);
    wait_req(cyc);
    check("p_rerun", 32'(cyc), 16);
    repeat (3) tick();
    check("req_held", 32'(move_req), 1);
    game_state = c_initial;
    tick();
    check("abort_req", 32'(move_req), 0);
    check("abort_phase", 32'(phase), c_ph_idle);

    game_state = c_running;
    tick();
    wait_req(cyc);
    do_step(1'b0, 1'b1, 6'd8, 1'b0);
    check("pre_rst_grow", 32'(grow_en), 1);
    check("pre_rst_count", 32'(step_count), 1);
    repeat (4) tick();
    #2;
    rst = 1'b0;
    #1;
    check("async_phase", 32'(phase), c_ph_idle);
    check("async_grow", 32'(grow_en), 0);
    check("async_count", 32'(step_count), 0);
    check("async_req", 32'(move_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
